// File: rtl/motor_pkg.sv
// Shared types for the conveyor motor sequencer: FSM state encoding and controlador_motor
// sel codes.
package motor_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRampUp,
    StRun,
    StRampDown,
    StBrake
  } state_e;

  localparam logic [1:0] SEL_COAST = 2'b00;
  localparam logic [1:0] SEL_CW    = 2'b01;
  localparam logic [1:0] SEL_CCW   = 2'b10;
  localparam logic [1:0] SEL_BRAKE = 2'b11;

  function automatic logic [1:0] sel_for_dir(input logic dir);
    return dir ? SEL_CCW : SEL_CW;
  endfunction

endpackage

// File: rtl/motor_secuenciador_if.sv
// Command and drive bundle between the conveyor control logic and motor_secuenciador.
interface motor_secuenciador_if;
  logic       start;
  logic       stop;
  logic       dir_req;
  logic [7:0] duty_target;
  logic       pieza;
  logic [7:0] count_target;
  logic [1:0] sel;
  logic [7:0] pwm_duty;
  logic       busy;
  logic       done;
  logic [7:0] piezas;

  modport master (
    output start, stop, dir_req, duty_target, pieza, count_target,
    input  sel, pwm_duty, busy, done, piezas
  );

  modport slave (
    input  start, stop, dir_req, duty_target, pieza, count_target,
    output sel, pwm_duty, busy, done, piezas
  );
endinterface

// File: rtl/detector_flanco.sv
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge pulse.
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  // [0],[1] synchronize; [2] holds the previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/motor_secuenciador.sv
// PWM ramp / brake sequencer in front of controlador_motor. Defining
// MOTOR_SECUENCIADOR_CONTADOR_EN enables the piece counter with automatic stop.
module motor_secuenciador
  import motor_pkg::*;
#(
  parameter int unsigned RAMP_DIV     = 50_000,
  parameter int unsigned RAMP_STEP    = 8,
  parameter int unsigned BRAKE_CYCLES = 500_000
) (
  input logic                 clk,
  input logic                 rst,
  motor_secuenciador_if.slave bus
);

  localparam int unsigned PrescW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned BrakeW = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(RAMP_DIV - 1);
  localparam logic [BrakeW-1:0] BrakeLast = BrakeW'(BRAKE_CYCLES - 1);
  localparam logic [7:0] Step = 8'(RAMP_STEP);

  state_e            state_q, state_d;
  logic              dir_lat_q, dir_lat_d;
  logic [7:0]        tgt_lat_q, tgt_lat_d;
  logic              reversa_q, reversa_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [BrakeW-1:0] brake_q, brake_d;
  logic [7:0]        duty_q, duty_d;
  logic [1:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        piezas_q, piezas_d;

  logic       start_ok;
  logic       tick;
  logic       count_hit;
  logic [8:0] up_sum;
  logic [7:0] up_next;
  logic [7:0] down_next;

  assign start_ok  = (state_q == StIdle) && bus.start && (bus.duty_target != 8'd0);
  assign tick      = (presc_q == PrescLast);
  // 9-bit sum so a step past 255 still saturates at the target
  assign up_sum    = {1'b0, duty_q} + {1'b0, Step};
  assign up_next   = (up_sum > {1'b0, tgt_lat_q}) ? tgt_lat_q : up_sum[7:0];
  assign down_next = (duty_q > Step) ? (duty_q - Step) : 8'd0;

  // Synthesis trims the synchronizer when the counter is disabled and the pulse is unused.
  logic pieza_pulse;

  detector_flanco u_detector_flanco (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.pieza),
    .pulse (pieza_pulse)
  );

`ifdef MOTOR_SECUENCIADOR_CONTADOR_EN
  logic [7:0] cnt_lat_q, cnt_lat_d;

  always_comb begin
    piezas_d  = piezas_q;
    cnt_lat_d = cnt_lat_q;
    if (start_ok) begin
      piezas_d  = 8'd0;
      cnt_lat_d = bus.count_target;
    end else if ((state_q == StRun) && pieza_pulse && (piezas_q != 8'hFF)) begin
      piezas_d = piezas_q + 8'd1;
    end
  end

  assign count_hit = (cnt_lat_q != 8'd0) && (piezas_q == cnt_lat_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lat_q <= 8'd0;
    end else begin
      cnt_lat_q <= cnt_lat_d;
    end
  end
`else
  logic unused_contador;

  assign unused_contador = ^{pieza_pulse, bus.count_target};
  assign piezas_d        = 8'd0;
  assign count_hit       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    dir_lat_d = dir_lat_q;
    tgt_lat_d = tgt_lat_q;
    reversa_d = reversa_q;
    duty_d    = duty_q;
    done_d    = 1'b0;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    brake_d   = '0;

    unique case (state_q)
      StIdle: begin
        duty_d = 8'd0;
        if (start_ok) begin
          dir_lat_d = bus.dir_req;
          tgt_lat_d = bus.duty_target;
          reversa_d = 1'b0;
          state_d   = StRampUp;
        end
      end
      StRampUp: begin
        if (bus.stop) begin
          reversa_d = 1'b0;
          state_d   = StRampDown;
        end else if (duty_q == tgt_lat_q) begin
          state_d = StRun;
        end else if (tick) begin
          duty_d = up_next;
        end
      end
      StRun: begin
        if (bus.stop || count_hit) begin
          reversa_d = 1'b0;
          state_d   = StRampDown;
        end else if (bus.dir_req != dir_lat_q) begin
          reversa_d = 1'b1;
          state_d   = StRampDown;
        end
      end
      StRampDown: begin
        if (bus.stop) begin
          reversa_d = 1'b0;
        end
        if (duty_q == 8'd0) begin
          state_d = StBrake;
        end else if (tick) begin
          duty_d = down_next;
        end
      end
      StBrake: begin
        duty_d  = 8'd0;
        brake_d = brake_q + 1'b1;
        if (bus.stop) begin
          reversa_d = 1'b0;
        end
        if (brake_q == BrakeLast) begin
          brake_d = '0;
          if (reversa_d) begin
            dir_lat_d = bus.dir_req;
            state_d   = StRampUp;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        duty_d  = 8'd0;
        state_d = StIdle;
      end
    endcase

    // Each ramp phase counts its first step from the entry edge
    if (state_d != state_q) begin
      presc_d = '0;
    end

    unique case (state_d)
      StIdle:  sel_d = SEL_COAST;
      StBrake: sel_d = SEL_BRAKE;
      default: sel_d = sel_for_dir(dir_lat_d);
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      dir_lat_q <= 1'b0;
      tgt_lat_q <= 8'd0;
      reversa_q <= 1'b0;
      presc_q   <= '0;
      brake_q   <= '0;
      duty_q    <= 8'd0;
      sel_q     <= SEL_COAST;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      piezas_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      dir_lat_q <= dir_lat_d;
      tgt_lat_q <= tgt_lat_d;
      reversa_q <= reversa_d;
      presc_q   <= presc_d;
      brake_q   <= brake_d;
      duty_q    <= duty_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      piezas_q  <= piezas_d;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.pwm_duty = duty_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.piezas   = piezas_q;

endmodule

// File: tb/tb_motor_secuenciador.sv
// Directed bench for motor_secuenciador with a cycle-by-cycle behavioural reference model.
module tb_motor_secuenciador;

  localparam int DIV  = 4;
  localparam int STEP = 32;
  localparam int BRK  = 8;

  localparam int MIdle  = 0;
  localparam int MUp    = 1;
  localparam int MRun   = 2;
  localparam int MDown  = 3;
  localparam int MBrake = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  motor_secuenciador_if bus ();

  motor_secuenciador #(
    .RAMP_DIV     (DIV),
    .RAMP_STEP    (STEP),
    .BRAKE_CYCLES (BRK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase + elapsed cycles since phase entry, ramp by min/max arithmetic
  int         m_mode = MIdle;
  int         m_el   = 0;
  int         m_tgt  = 0;
  int         m_cnt  = 0;
  bit         m_dir  = 1'b0;
  bit         m_rev  = 1'b0;
  bit   [2:0] m_hist = 3'b000;
  bit         m_rise;
  bit         m_hit;
  int         e_duty   = 0;
  int         e_piezas = 0;
  logic [1:0] e_sel    = 2'b00;
  bit         e_busy   = 1'b0;
  bit         e_done   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = MIdle; m_el = 0; m_tgt = 0; m_cnt = 0; m_dir = 0; m_rev = 0; m_hist = 3'b000;
      e_duty = 0; e_piezas = 0; e_done = 0;
    end else begin
      // sensor level seen two edges ago is high, three edges ago low
      m_rise = m_hist[1] & ~m_hist[2];
      m_hit  = 1'b0;
      e_done = 1'b0;
      m_hist = {m_hist[1:0], bus.pieza};
`ifdef MOTOR_SECUENCIADOR_CONTADOR_EN
      m_hit = (m_cnt != 0) && (e_piezas == m_cnt);
      if (m_mode == MRun && m_rise && e_piezas < 255) e_piezas++;
`endif
      case (m_mode)
        MIdle: begin
          e_duty = 0;
          if (bus.start && bus.duty_target != 0) begin
            m_dir = bus.dir_req; m_tgt = bus.duty_target; m_cnt = bus.count_target;
            e_piezas = 0; m_rev = 0; m_mode = MUp; m_el = 0;
          end
        end
        MUp: begin
          if (bus.stop) begin
            m_mode = MDown; m_el = 0; m_rev = 0;
          end else if (e_duty == m_tgt) begin
            m_mode = MRun;
          end else begin
            m_el++;
            if (m_el % DIV == 0) e_duty = (e_duty + STEP < m_tgt) ? e_duty + STEP : m_tgt;
          end
        end
        MRun: begin
          if (bus.stop || m_hit) begin
            m_mode = MDown; m_el = 0; m_rev = 0;
          end else if (bus.dir_req != m_dir) begin
            m_mode = MDown; m_el = 0; m_rev = 1;
          end
        end
        MDown: begin
          if (bus.stop) m_rev = 0;
          if (e_duty == 0) begin
            m_mode = MBrake; m_el = 0;
          end else begin
            m_el++;
            if (m_el % DIV == 0) e_duty = (e_duty > STEP) ? e_duty - STEP : 0;
          end
        end
        default: begin
          if (bus.stop) m_rev = 0;
          m_el++;
          if (m_el == BRK) begin
            if (m_rev) begin
              m_dir = bus.dir_req; m_mode = MUp; m_el = 0;
            end else begin
              m_mode = MIdle; e_done = 1'b1;
            end
          end
        end
      endcase
    end
    e_sel  = (m_mode == MIdle) ? 2'b00 : (m_mode == MBrake) ? 2'b11 : (m_dir ? 2'b10 : 2'b01);
    e_busy = (m_mode != MIdle);
  end

  always @(posedge clk) begin
    #1;
    check("model_sel", bus.sel, e_sel);
    check("model_duty", bus.pwm_duty, e_duty);
    check("model_busy", bus.busy, e_busy);
    check("model_done", bus.done, e_done);
    check("model_piezas", bus.piezas, e_piezas);
  end

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic dir, input logic [7:0] tgt, input logic [7:0] ct);
    bus.dir_req      = dir;
    bus.duty_target  = tgt;
    bus.count_target = ct;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.dir_req = 1'b0;
    bus.duty_target = 8'd0; bus.count_target = 8'd0; bus.pieza = 1'b0;
    tick(3);
    check("rst_sel", bus.sel, 0);
    check("rst_duty", bus.pwm_duty, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_piezas", bus.piezas, 0);
    rst = 1'b0;
    tick(2);

    // start with zero target is ignored
    pulse_start(1'b0, 8'd0, 8'd0);
    check("zero_tgt_busy", bus.busy, 0);
    tick(1);

    // ramp up to 128
    pulse_start(1'b0, 8'd128, 8'd0);
    check("up_sel", bus.sel, 2'b01);
    check("up_busy", bus.busy, 1);
    check("up_duty0", bus.pwm_duty, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(4);
      check("up_duty", bus.pwm_duty, 32 * k);
    end
    tick(5);
    check("run_busy", bus.busy, 1);
    check("run_duty", bus.pwm_duty, 128);

    // stop from RUN
    pulse_stop();
    for (int k = 1; k <= 4; k++) begin
      tick(4);
      check("down_duty", bus.pwm_duty, 128 - 32 * k);
    end
    tick(1);
    check("brake_sel_first", bus.sel, 2'b11);
    tick(7);
    check("brake_sel_last", bus.sel, 2'b11);
    tick(1);
    check("stop_sel", bus.sel, 2'b00);
    check("stop_done", bus.done, 1);
    check("stop_busy", bus.busy, 0);
    tick(1);
    check("done_one_cycle", bus.done, 0);

    // reversal through zero and brake
    tick(2);
    done_cnt = 0;
    pulse_start(1'b0, 8'd128, 8'd0);
    tick(17);
    bus.dir_req = 1'b1;
    tick(17);
    check("rev_zero_duty", bus.pwm_duty, 0);
    check("rev_zero_sel", bus.sel, 2'b01);
    tick(1);
    check("rev_brake_sel", bus.sel, 2'b11);
    tick(8);
    check("rev_ccw_sel", bus.sel, 2'b10);
    check("rev_ccw_duty", bus.pwm_duty, 0);
    tick(16);
    check("rev_ccw_top", bus.pwm_duty, 128);
    tick(1);
    check("rev_no_done", done_cnt, 0);
    pulse_stop();
    wait_done(40, "rev_stop_done");

    // saturating ramp to 100
    tick(2);
    pulse_start(1'b1, 8'd100, 8'd0);
    tick(4); check("sat_up_32", bus.pwm_duty, 32);
    tick(4); check("sat_up_64", bus.pwm_duty, 64);
    tick(4); check("sat_up_96", bus.pwm_duty, 96);
    tick(4); check("sat_up_100", bus.pwm_duty, 100);
    tick(1);
    pulse_stop();
    tick(4); check("sat_dn_68", bus.pwm_duty, 68);
    tick(4); check("sat_dn_36", bus.pwm_duty, 36);
    tick(4); check("sat_dn_4", bus.pwm_duty, 4);
    tick(4); check("sat_dn_0", bus.pwm_duty, 0);
    wait_done(20, "sat_done");

    // piece counter
    tick(2);
    pulse_start(1'b1, 8'd64, 8'd3);
    tick(9);
    check("cnt_run_duty", bus.pwm_duty, 64);
    for (int p = 0; p < 3; p++) begin
      bus.pieza = 1'b1;
      tick(2);
      bus.pieza = 1'b0;
      tick(2);
    end
`ifdef MOTOR_SECUENCIADOR_CONTADOR_EN
    check("cnt_piezas", bus.piezas, 3);
    wait_done(40, "cnt_autostop_done");
    check("cnt_piezas_after", bus.piezas, 3);
`else
    tick(10);
    check("cnt_piezas_off", bus.piezas, 0);
    check("cnt_still_busy", bus.busy, 1);
    check("cnt_still_duty", bus.pwm_duty, 64);
    pulse_stop();
    wait_done(40, "cnt_manual_done");
`endif

    // asynchronous reset mid-ramp
    tick(2);
    pulse_start(1'b0, 8'd128, 8'd0);
    tick(8);
    check("rstmid_pre_duty", bus.pwm_duty, 64);
    rst = 1'b1;
    #1;
    check("rstmid_sel", bus.sel, 0);
    check("rstmid_duty", bus.pwm_duty, 0);
    check("rstmid_busy", bus.busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    pulse_start(1'b0, 8'd128, 8'd0);
    check("restart_duty0", bus.pwm_duty, 0);
    check("restart_sel", bus.sel, 2'b01);
    tick(4);
    check("restart_duty32", bus.pwm_duty, 32);
    pulse_stop();
    wait_done(40, "restart_done");

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_secuenciador.md
# motor_secuenciador

Sequencer that sits in front of `controlador_motor` and drives its `sel` and `pwm_duty` inputs. It accepts start/stop/direction commands from the conveyor control logic and applies a linear PWM ramp up and down. Every direction reversal passes through zero duty and a timed brake, so the H-bridge never reverses under load. An optional piece counter stops the belt automatically after a programmed number of sensor pulses.

## Interface
- `RAMP_DIV`, default 50_000: clocks per ramp step (1 ms at 50 MHz).
- `RAMP_STEP`, default 8: duty increment/decrement per step.
- `BRAKE_CYCLES`, default 500_000: brake hold, 10 ms.
- `clk`, in, 1: system clock, 50 MHz.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle run request.
- `stop`, in, 1: one-cycle stop request.
- `dir_req`, in, 1: 0 = clockwise, 1 = counter-clockwise.
- `duty_target`, in, 8: run duty, sampled on accepted `start`.
- `pieza`, in, 1: raw asynchronous piece-sensor level.
- `count_target`, in, 8: pieces before auto-stop, sampled on `start`; 0 = unlimited.
- `sel`, out, 2: to `controlador_motor`. 00 = coast, 01 = clockwise, 10 = counter-clockwise, 11 = brake/protection.
- `pwm_duty`, out, 8: to `controlador_motor`.
- `busy`, out, 1: high when the state is not IDLE.
- `done`, out, 1: one-cycle pulse when a stop sequence completes.
- `piezas`, out, 8: pieces counted in the current run.

## Operation
- All outputs are registered.
- Reset value of every output is 0; state resets to IDLE.
- Internal registers: `dir_lat`, `tgt_lat`, `cnt_lat`, `reversa` flag, ramp prescaler, brake counter.
- IDLE:
  - Outputs: `sel`=00, `pwm_duty`=0.
  - On `start` with `duty_target`≠0: latch `dir_req`, `duty_target` and `count_target`; clear `piezas`; go to RAMP_UP.
  - `start` with `duty_target`=0 is ignored.
- RAMP_UP:
  - `sel` = 01 if `dir_lat`=0, else 10.
  - On each prescaler tick: `duty = min(duty + RAMP_STEP, tgt_lat)`, computed 9-bit with saturation.
  - When `duty == tgt_lat`, go to RUN.
- RUN:
  - `sel` follows `dir_lat`; `duty` is held.
  - Exit priority: `stop` > count reached > `dir_req != dir_lat`. The first two go to RAMP_DOWN with `reversa`=0; direction mismatch goes to RAMP_DOWN with `reversa`=1.
- RAMP_DOWN:
  - On each tick: `duty = max(duty − RAMP_STEP, 0)`.
  - When `duty == 0`, go to BRAKE.
  - `stop` during RAMP_UP jumps to RAMP_DOWN on the next cycle, `reversa`=0.
  - `stop` during RAMP_DOWN clears `reversa`.
- BRAKE:
  - Outputs: `sel`=11, `duty`=0, held for exactly `BRAKE_CYCLES` clocks.
  - Then, if `reversa`=1: `dir_lat` ← current `dir_req`; go to RAMP_UP.
  - Otherwise: go to IDLE and pulse `done`.
  - `stop` during BRAKE clears `reversa`.
- `start` outside IDLE is ignored.
- `duty_target` changes after `start` are ignored.

## Timing
- `start` sampled at edge N: `busy` and `sel` update at edge N+1.
- Prescaler clears on entry to RAMP_UP/RAMP_DOWN. The first step occurs `RAMP_DIV` cycles after entry, then every `RAMP_DIV` cycles.
- The RAMP_UP→RUN and RAMP_DOWN→BRAKE transitions happen on the edge after the final step.
- `done` asserts on the same edge as BRAKE→IDLE; `busy` falls on that edge.
- `pieza` path:
  - 2-FF synchronizer, then rising-edge detect.
  - Count edges only in RUN.
  - Latency from a `pieza` rise to the `piezas` increment: 3 cycles.
- Asynchronous reset mid-operation: outputs go to 0 immediately and the state returns to IDLE. There is no ramp-down.

## Configuration
- `MOTOR_SECUENCIADOR_CONTADOR_EN` defined:
  - Synchronizer and counter are present.
  - `piezas` saturates at 255.
  - When `cnt_lat`≠0 and `piezas == cnt_lat` in RUN, stop sequence starts.
- Not defined:
  - `pieza` and `count_target` are ignored.
  - `piezas` is tied to 0.
  - No auto-stop.

## Structure
- Package `motor_pkg`:
  - State encoding: IDLE, RAMP_UP, RUN, RAMP_DOWN, BRAKE.
  - `sel` constants: SEL_COAST, SEL_CW, SEL_CCW, SEL_BRAKE.
- Sub-module `detector_flanco`: 2-FF synchronizer plus rising-edge pulse, used for `pieza`.

## Test plan
All scenarios use `RAMP_DIV`=4, `RAMP_STEP`=32, `BRAKE_CYCLES`=8.
- Ramp up: `start`, `dir_req`=0, target 128 → `sel`=01; duty 32, 64, 96, 128 at 4-cycle spacing; then RUN with `busy`=1.
- Stop from RUN: `stop` → duty 96, 64, 32, 0; `sel`=11 for 8 cycles; then `sel`=00, `done`=1 for one cycle, `busy`=0.
- Reversal: in RUN, set `dir_req`=1 → ramp to 0, `sel`=11 for 8 cycles, `sel`=10, ramp back to 128; `done` never asserted.
- Saturation: target 100 → duty 32, 64, 96, 100; then `stop` → 68, 36, 4, 0.
- Auto-stop (macro defined): `count_target`=3, three `pieza` pulses in RUN → `piezas`=3, ramp down, `done` pulse. With the macro undefined, `piezas` stays 0 and the belt keeps running.
- Reset mid-ramp: `rst` at duty 64 → `sel`=00, `pwm_duty`=0, `busy`=0 immediately; a later `start` restarts from duty 0.
